// File: rtl/phy_power_ctrl_pkg.sv
// Shared encodings for the PHY power sequencer: PIPE power states, RXSTATUS
// codes and the sequencer FSM state enum.
package phy_power_ctrl_pkg;

    typedef enum logic [1:0] {
        PWR_P0  = 2'b00,
        PWR_P0S = 2'b01,
        PWR_P1  = 2'b10,
        PWR_P2  = 2'b11
    } pwr_t;

    localparam logic [2:0] RXSTAT_OK  = 3'b000;
    localparam logic [2:0] RXSTAT_DET = 3'b011;

    typedef enum logic [2:0] {
        ST_LOCK   = 3'd0,
        ST_P0     = 3'd1,
        ST_P0S    = 3'd2,
        ST_P1     = 3'd3,
        ST_P2     = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DETECT = 3'd6,
        ST_REPORT = 3'd7
    } state_t;

endpackage

// File: rtl/phy_power_ctrl.sv
// PHY power sequencer: tracks PWRDDWN, gates the TX clock, drives TXIDLE,
// the PHYSTATUS handshake and the receiver-detect sequence.
module phy_power_ctrl
    import phy_power_ctrl_pkg::*;
#(
    parameter int LOCK_CYCLES   = 16,
    parameter int P0S_EXIT      = 4,
    parameter int P1_EXIT       = 8,
    parameter int P2_EXIT       = 32,
    parameter int DETECT_CYCLES = 12,
    parameter int CNT_W         = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] PWRDDWN,
    input  logic       RXDET_LOOPB,
    input  logic       TXELECIDLE,
    input  logic       RXDET_O,
    output logic       TXIDLE,
    output logic       RXDET,
    output logic       DATALOOP,
    output logic       TRANSCLK_EN,
    output logic       PHYSTATUS,
    output logic [2:0] RXSTATUS,
    output state_t     dbg_state_o
);

    state_t             state_q;
    pwr_t               target_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               armed_q;
    pwr_t               cur_pwr;
    pwr_t               req_pwr;

    // Settle length is set by the lower-power endpoint; loaded as count-1 so
    // the target is entered settle+1 edges after the request is seen.
    function automatic logic [CNT_W-1:0] settle_load(input pwr_t a, input pwr_t b);
        if (a == PWR_P2 || b == PWR_P2) return CNT_W'(P2_EXIT - 1);
        if (a == PWR_P1 || b == PWR_P1) return CNT_W'(P1_EXIT - 1);
        return CNT_W'(P0S_EXIT - 1);
    endfunction

    function automatic state_t pwr_to_state(input pwr_t p);
        case (p)
            PWR_P0:  return ST_P0;
            PWR_P0S: return ST_P0S;
            PWR_P1:  return ST_P1;
            default: return ST_P2;
        endcase
    endfunction

    assign req_pwr     = pwr_t'(PWRDDWN);
    assign dbg_state_o = state_q;

    // REPORT resolves back into P1, so it compares against P1 as well.
    always_comb begin
        cur_pwr = PWR_P1;
        case (state_q)
            ST_P0:   cur_pwr = PWR_P0;
            ST_P0S:  cur_pwr = PWR_P0S;
            ST_P2:   cur_pwr = PWR_P2;
            default: cur_pwr = PWR_P1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOCK;
            target_q    <= PWR_P1;
            cnt_q       <= '0;
            armed_q     <= 1'b1;
            PHYSTATUS   <= 1'b1;
            TXIDLE      <= 1'b1;
            TRANSCLK_EN <= 1'b0;
            RXDET       <= 1'b0;
            DATALOOP    <= 1'b0;
            RXSTATUS    <= RXSTAT_OK;
        end else begin
            PHYSTATUS <= 1'b0;
            RXSTATUS  <= RXSTAT_OK;
            DATALOOP  <= 1'b0;
            // A new detect needs RXDET_LOOPB to have dropped since the last one.
            if (state_q != ST_DETECT && state_q != ST_REPORT && !RXDET_LOOPB)
                armed_q <= 1'b1;

            case (state_q)
                ST_LOCK: begin
                    // Lock phase counts up from the reset value of zero.
                    PHYSTATUS   <= 1'b1;
                    TXIDLE      <= 1'b1;
                    TRANSCLK_EN <= 1'b0;
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_q   <= ST_P1;
                        cnt_q     <= '0;
                        PHYSTATUS <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_P0, ST_P0S, ST_P1, ST_P2, ST_REPORT: begin
                    if (req_pwr != cur_pwr) begin
                        state_q  <= ST_SETTLE;
                        target_q <= req_pwr;
                        cnt_q    <= settle_load(cur_pwr, req_pwr);
                        if (req_pwr == PWR_P0 || req_pwr == PWR_P0S)
                            TRANSCLK_EN <= 1'b1;
                    end else if (state_q == ST_P1 && RXDET_LOOPB && armed_q) begin
                        state_q <= ST_DETECT;
                        cnt_q   <= CNT_W'(DETECT_CYCLES - 1);
                        RXDET   <= 1'b1;
                        armed_q <= 1'b0;
                    end else begin
                        if (state_q == ST_REPORT)
                            state_q <= ST_P1;
                        if (state_q == ST_P0) begin
                            TXIDLE   <= TXELECIDLE;
                            DATALOOP <= RXDET_LOOPB;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_q     <= pwr_to_state(target_q);
                        PHYSTATUS   <= 1'b1;
                        TRANSCLK_EN <= (target_q == PWR_P0 || target_q == PWR_P0S);
                        TXIDLE      <= (target_q == PWR_P0) ? TXELECIDLE : 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                ST_DETECT: begin
                    if (cnt_q == '0) begin
                        state_q   <= ST_REPORT;
                        RXDET     <= 1'b0;
                        PHYSTATUS <= 1'b1;
                        RXSTATUS  <= RXDET_O ? RXSTAT_DET : RXSTAT_OK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                default: state_q <= ST_LOCK;
            endcase
        end
    end

endmodule
